// File: rtl/vhdci_link_pkg.sv
// Shared types and constants for the VHDCI link arbiter.
// VHDCI_LINK_ARB_CSUM_EN adds the trailer state used for the checksum word.
package vhdci_link_pkg;
  localparam int NUM_CH       = 4;
  localparam int CH_W         = 2;
  localparam int LEN_W        = 4;
  localparam int PAY_W        = 6;
  localparam int WORD_W       = 7;
  localparam int HDR_FLAG_BIT = 6;
  localparam int HDR_CH_LSB   = 4;
  localparam int HDR_LEN_LSB  = 0;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_PAY  = 3'd2,
`ifdef VHDCI_LINK_ARB_CSUM_EN
    ST_TRL  = 3'd3,
`endif
    ST_GAP  = 3'd4
  } st_t;

  function automatic logic [WORD_W-1:0] mk_hdr(input logic [CH_W-1:0] ch,
                                               input logic [LEN_W-1:0] len);
    logic [WORD_W-1:0] h;
    h = '0;
    h[HDR_FLAG_BIT]              = 1'b1;
    h[HDR_CH_LSB +: CH_W]        = ch;
    h[HDR_LEN_LSB +: LEN_W]      = len;
    return h;
  endfunction
endpackage

// File: rtl/vhdci_rr_arb.sv
// 4-way round-robin: first requester after last_grant wins, wrapping 3->0.
module vhdci_rr_arb
  import vhdci_link_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   last_grant,
  output logic              gnt_vld,
  output logic [CH_W-1:0]   gnt_idx
);
  logic [CH_W-1:0] cand;

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = last_grant;
    cand    = '0;
    // offset NUM_CH wraps back to last_grant itself, so it is checked last
    for (int i = 1; i <= NUM_CH; i++) begin
      cand = last_grant + CH_W'(i);
      if (!gnt_vld && req[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end
endmodule

// File: rtl/vhdci_link_arb.sv
// Packetizing arbiter for the VHDCI mux: header, payload, optional checksum
// trailer (VHDCI_LINK_ARB_CSUM_EN), then an idle gap.
module vhdci_link_arb
  import vhdci_link_pkg::*;
#(
  parameter int         GAP_CYCLES = 1,
  parameter logic [6:0] IDLE_WORD  = 7'h00
) (
  input  logic        clk_mux_div,
  input  logic        reset_sync,
  input  logic        mux_synced,
  input  logic [3:0]  ch_req,
  input  logic [15:0] ch_len,
  input  logic [23:0] ch_data,
  output logic [3:0]  ch_start,
  output logic [3:0]  ch_pop,
  output logic [3:0]  ch_abort,
  output logic [6:0]  link_data_out,
  output logic        busy
);
  localparam logic [2:0] GAP_LAST = 3'(GAP_CYCLES - 1);
`ifdef VHDCI_LINK_ARB_CSUM_EN
  localparam st_t PKT_END = ST_TRL;
`else
  localparam st_t PKT_END = ST_GAP;
`endif

  st_t               state, state_nxt;
  logic [CH_W-1:0]   g, last_grant, gnt_idx;
  logic              gnt_vld, grant;
  logic [LEN_W-1:0]  len_q, cnt;
  logic [2:0]        gap_cnt;
  logic [WORD_W-1:0] link_nxt, hdr_word;
  logic [PAY_W-1:0]  cur_data;
`ifdef VHDCI_LINK_ARB_CSUM_EN
  logic [PAY_W-1:0]  csum;
`endif

  vhdci_rr_arb u_rr (
    .req        (ch_req),
    .last_grant (last_grant),
    .gnt_vld    (gnt_vld),
    .gnt_idx    (gnt_idx)
  );

  assign grant    = (state == ST_IDLE) && mux_synced && gnt_vld;
  assign hdr_word = mk_hdr(g, len_q);
  assign cur_data = ch_data[g*PAY_W +: PAY_W];
  assign busy     = (state != ST_IDLE);

  always_comb begin
    state_nxt = state;
    link_nxt  = IDLE_WORD;
    ch_start  = '0;
    ch_pop    = '0;
    ch_abort  = '0;
    case (state)
      ST_IDLE: if (grant) state_nxt = ST_HDR;
      ST_HDR: begin
        if (!mux_synced) begin
          ch_abort[g] = 1'b1;
          state_nxt   = ST_GAP;
        end else begin
          ch_start[g] = 1'b1;
          link_nxt    = hdr_word;
          state_nxt   = (len_q == '0) ? PKT_END : ST_PAY;
        end
      end
      ST_PAY: begin
        // pop is gated by sync so a lost link never consumes another word
        if (!mux_synced) begin
          ch_abort[g] = 1'b1;
          state_nxt   = ST_GAP;
        end else begin
          ch_pop[g] = 1'b1;
          link_nxt  = {1'b0, cur_data};
          if (cnt == len_q - LEN_W'(1)) state_nxt = PKT_END;
        end
      end
`ifdef VHDCI_LINK_ARB_CSUM_EN
      ST_TRL: begin
        if (!mux_synced) begin
          ch_abort[g] = 1'b1;
        end else begin
          link_nxt = {1'b0, csum};
        end
        state_nxt = ST_GAP;
      end
`endif
      ST_GAP: if (gap_cnt == GAP_LAST) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_mux_div or posedge reset_sync) begin
    if (reset_sync) begin
      state         <= ST_IDLE;
      g             <= '0;
      last_grant    <= CH_W'(NUM_CH - 1);
      len_q         <= '0;
      cnt           <= '0;
      gap_cnt       <= '0;
      link_data_out <= IDLE_WORD;
`ifdef VHDCI_LINK_ARB_CSUM_EN
      csum          <= '0;
`endif
    end else begin
      state         <= state_nxt;
      link_data_out <= link_nxt;
      // length is latched so a requester dropping ch_req cannot disturb the packet
      if (grant) begin
        g          <= gnt_idx;
        last_grant <= gnt_idx;
        len_q      <= ch_len[gnt_idx*LEN_W +: LEN_W];
      end
      cnt     <= (state == ST_PAY) ? cnt + LEN_W'(1) : '0;
      gap_cnt <= (state == ST_GAP) ? gap_cnt + 3'd1 : '0;
`ifdef VHDCI_LINK_ARB_CSUM_EN
      if (state == ST_HDR)                    csum <= hdr_word[PAY_W-1:0];
      else if (state == ST_PAY && mux_synced) csum <= csum ^ cur_data;
`endif
    end
  end
endmodule

// File: tb/tb_vhdci_link_arb.sv
// Self-checking bench for vhdci_link_arb: table of single-channel packets plus
// round-robin, sync-loss and mid-packet reset sequences, scoreboarded link words.
module tb_vhdci_link_arb;
  localparam int         GAP  = 2;
  localparam logic [6:0] IDLE = 7'h00;

  logic        clk_mux_div, reset_sync, mux_synced;
  logic [3:0]  ch_req, ch_start, ch_pop, ch_abort;
  logic [15:0] ch_len;
  logic [23:0] ch_data;
  logic [6:0]  link_data_out;
  logic        busy;

  vhdci_link_arb #(.GAP_CYCLES(GAP), .IDLE_WORD(IDLE)) dut (
    .clk_mux_div   (clk_mux_div),
    .reset_sync    (reset_sync),
    .mux_synced    (mux_synced),
    .ch_req        (ch_req),
    .ch_len        (ch_len),
    .ch_data       (ch_data),
    .ch_start      (ch_start),
    .ch_pop        (ch_pop),
    .ch_abort      (ch_abort),
    .link_data_out (link_data_out),
    .busy          (busy)
  );

  initial clk_mux_div = 1'b0;
  always #5 clk_mux_div = ~clk_mux_div;

  typedef struct {
    logic [6:0]        hdr;
    int                n;
    logic [23:0][6:0]  w;
  } pkt_t;

  typedef struct {
    int               ch;
    int               len;
    logic [3:0][5:0]  d;
    logic [6:0]       hdr;
    logic [6:0]       csum;
  } vec_t;

  pkt_t       sb[$];
  pkt_t       mon_cur;
  int         mon_rem, mon_pos;
  int         n_chk, n_err;
  logic [5:0] pay_mem [4][16];
  int         rd_idx [4];
  int         pop_cnt [4];
  int         start_cnt, abort_cnt;
  logic [3:0] abort_or, s_pop, s_start, s_abort;
  vec_t       tbl [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_data();
    for (int c = 0; c < 4; c++)
      ch_data[c*6 +: 6] = (rd_idx[c] < 16) ? pay_mem[c][rd_idx[c]] : 6'h00;
  endtask

  task automatic start_req(input int c, input int len);
    ch_len[c*4 +: 4] = 4'(len);
    rd_idx[c] = 0;
    ch_req[c] = 1'b1;
    drive_data();
  endtask

  function automatic logic [6:0] csum_of(input logic [6:0] hdr, input int c, input int n);
    logic [5:0] x;
    x = hdr[5:0];
    for (int i = 0; i < n; i++) x = x ^ pay_mem[c][i];
    return {1'b0, x};
  endfunction

  task automatic push_pkt(input logic [6:0] hdr, input int c, input int npay,
                          input logic [6:0] csum, input bit aborted);
    pkt_t p;
    p.hdr = hdr;
    p.w   = '0;
    p.n   = 0;
    for (int i = 0; i < npay; i++) begin
      p.w[p.n] = {1'b0, pay_mem[c][i]};
      p.n++;
    end
`ifdef VHDCI_LINK_ARB_CSUM_EN
    if (!aborted) begin
      p.w[p.n] = csum;
      p.n++;
    end
`endif
    for (int i = 0; i < GAP; i++) begin
      p.w[p.n] = IDLE;
      p.n++;
    end
    sb.push_back(p);
  endtask

  task automatic monitor();
    if (mon_rem > 0) begin
      chk("link_word", 32'(link_data_out), 32'(mon_cur.w[mon_pos]));
      mon_pos++;
      mon_rem--;
    end else if (link_data_out[6]) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL unexpected_header: got 0x%0h, expected no packet", link_data_out);
      end else begin
        mon_cur = sb.pop_front();
        chk("header", 32'(link_data_out), 32'(mon_cur.hdr));
        mon_pos = 0;
        mon_rem = mon_cur.n;
      end
    end
  endtask

  // One clock: sample outputs at negedge, then update the requester model after the edge.
  task automatic tick();
    @(negedge clk_mux_div);
    s_pop   = ch_pop;
    s_start = ch_start;
    s_abort = ch_abort;
    if (!reset_sync) begin
      chk("onehot", 32'({$onehot0(s_start), $onehot0(s_pop), $onehot0(s_abort)}), 32'h7);
      for (int c = 0; c < 4; c++) begin
        if (s_pop[c])   pop_cnt[c]++;
        if (s_start[c]) start_cnt++;
        if (s_abort[c]) abort_cnt++;
      end
      abort_or = abort_or | s_abort;
      monitor();
    end
    @(posedge clk_mux_div);
    #1;
    if (!reset_sync) begin
      for (int c = 0; c < 4; c++) begin
        if (s_pop[c]) rd_idx[c]++;
        if (s_start[c] || s_abort[c]) ch_req[c] = 1'b0;
      end
    end
    drive_data();
  endtask

  task automatic wait_done(input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      if (sb.size() == 0 && mon_rem == 0 && !busy) done = 1'b1;
      else tick();
    end
    chk("done_in_time", 32'(done), 32'h1);
  endtask

  task automatic chk_quiet(input string name);
    chk(name, 32'({link_data_out, busy, ch_start, ch_pop, ch_abort}), 32'({IDLE, 13'h0}));
  endtask

  initial begin
    int p0, s0, a0;
    n_chk = 0; n_err = 0; mon_rem = 0; mon_pos = 0;
    start_cnt = 0; abort_cnt = 0; abort_or = '0;
    for (int c = 0; c < 4; c++) begin
      rd_idx[c] = 0; pop_cnt[c] = 0;
      for (int i = 0; i < 16; i++) pay_mem[c][i] = 6'h00;
    end
    reset_sync = 1'b1; mux_synced = 1'b1;
    ch_req = '0; ch_len = '0; ch_data = '0;

    tbl[0] = '{0, 3, {6'h00, 6'h3F, 6'h2A, 6'h15}, 7'h43, 7'h03};
    tbl[1] = '{1, 0, {6'h00, 6'h00, 6'h00, 6'h00}, 7'h50, 7'h10};
    tbl[2] = '{0, 2, {6'h00, 6'h00, 6'h02, 6'h01}, 7'h42, 7'h01};
    tbl[3] = '{3, 4, {6'h0D, 6'h0C, 6'h0B, 6'h0A}, 7'h74, 7'h34};
    tbl[4] = '{2, 1, {6'h00, 6'h00, 6'h00, 6'h3F}, 7'h61, 7'h1E};

    #12;
    chk_quiet("reset_state");
    @(posedge clk_mux_div);
    #1;
    reset_sync = 1'b0;

    // all four channels at once from reset: ch0..ch3 in order
    for (int c = 0; c < 4; c++) begin
      pay_mem[c][0] = 6'(6'h30 + c);
      start_req(c, 1);
    end
    push_pkt(7'h41, 0, 1, csum_of(7'h41, 0, 1), 1'b0);
    push_pkt(7'h51, 1, 1, csum_of(7'h51, 1, 1), 1'b0);
    push_pkt(7'h61, 2, 1, csum_of(7'h61, 2, 1), 1'b0);
    push_pkt(7'h71, 3, 1, csum_of(7'h71, 3, 1), 1'b0);
    wait_done(100);

    for (int t = 0; t < 5; t++) begin
      p0 = pop_cnt[tbl[t].ch];
      s0 = start_cnt;
      for (int i = 0; i < 4; i++) pay_mem[tbl[t].ch][i] = tbl[t].d[i];
      start_req(tbl[t].ch, tbl[t].len);
      push_pkt(tbl[t].hdr, tbl[t].ch, tbl[t].len, tbl[t].csum, 1'b0);
      wait_done(60);
      chk("pop_count", 32'(pop_cnt[tbl[t].ch] - p0), 32'(tbl[t].len));
      chk("start_count", 32'(start_cnt - s0), 32'h1);
    end

    // sync lost during the third payload cycle of a len=5 ch2 packet
    for (int i = 0; i < 5; i++) pay_mem[2][i] = 6'(6'h11 + i);
    p0 = pop_cnt[2]; a0 = abort_cnt; abort_or = '0;
    start_req(2, 5);
    push_pkt(7'h65, 2, 2, 7'h00, 1'b1);
    for (int i = 0; i < 30 && pop_cnt[2] - p0 < 2; i++) tick();
    chk("two_pops_seen", 32'(pop_cnt[2] - p0), 32'h2);
    mux_synced = 1'b0;
    pay_mem[3][0] = 6'h2A; pay_mem[3][1] = 6'h15; pay_mem[0][0] = 6'h07;
    start_req(3, 2);
    start_req(0, 1);
    s0 = start_cnt;
    for (int i = 0; i < 8; i++) tick();
    chk("abort_vec", 32'(abort_or), 32'h4);
    chk("abort_count", 32'(abort_cnt - a0), 32'h1);
    chk("pops_after_abort", 32'(pop_cnt[2] - p0), 32'h2);
    chk("no_grant_unsynced", 32'({busy, link_data_out, 4'(start_cnt - s0)}), 32'h0);
    push_pkt(7'h72, 3, 2, csum_of(7'h72, 3, 2), 1'b0);
    push_pkt(7'h41, 0, 1, csum_of(7'h41, 0, 1), 1'b0);
    mux_synced = 1'b1;
    wait_done(100);

    // asynchronous reset in the middle of a ch2 payload; ch0 must win afterwards
    for (int i = 0; i < 8; i++) pay_mem[2][i] = 6'(6'h20 + i);
    p0 = pop_cnt[2];
    start_req(2, 8);
    push_pkt(7'h68, 2, 8, csum_of(7'h68, 2, 8), 1'b0);
    for (int i = 0; i < 30 && pop_cnt[2] - p0 < 3; i++) tick();
    chk("pops_before_reset", 32'(pop_cnt[2] - p0), 32'h3);
    #2;
    reset_sync = 1'b1;
    #1;
    chk_quiet("async_reset");
    sb.delete();
    mon_rem = 0;
    ch_req = '0;
    tick();
    tick();
    reset_sync = 1'b0;
    #1;
    chk_quiet("after_release");
    pay_mem[0][0] = 6'h21; pay_mem[0][1] = 6'h22; pay_mem[3][0] = 6'h33;
    start_req(3, 1);
    start_req(0, 2);
    push_pkt(7'h42, 0, 2, csum_of(7'h42, 0, 2), 1'b0);
    push_pkt(7'h71, 3, 1, csum_of(7'h71, 3, 1), 1'b0);
    wait_done(100);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected end of test");
    $fatal(1, "watchdog");
  end
endmodule
